// File: rtl/exmem_pipe_stage.sv
// rtl/exmem_pipe_stage.sv - execute/memory pipeline stage: ALU, external FPU wait, byte-addressable data RAM
//
// Purpose: accepts one operation at a time, computes an ALU result or waits
// FPU_LAT cycles for an external FPU result. It then uses that result as a
// byte address for an optional load/store into a local RAM and presents the
// outcome on a valid/ready response port.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid / in_ready              operation handshake
//   src_a, src_af, src_bf            integer A, float A, float B operands
//   write_data, imm_ext              integer B / store data, immediate
//   alu_src, fpu_a_sel, alu_control  ALU B select, FPU A select, ALU op
//   fpu_sel_in, dsrc, mem_src        FPU op, result select, store data select
//   mem_write, mem_read, funct3      store/load request, size + zero-extend
//   fpu_a, fpu_b, fpu_op             operands/op presented to the external FPU
//   fpu_result                       external FPU result
//   out_valid / out_ready            result handshake
//   out_result, out_read_data        ALU/FPU result, load data
//   out_zero, out_err                ALU zero flag, access error
module exmem_pipe_stage #(
  parameter int DEPTH_WORDS = 64,
  parameter int FPU_LAT     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] src_a,
  input  logic [31:0] src_af,
  input  logic [31:0] src_bf,
  input  logic [31:0] write_data,
  input  logic [31:0] imm_ext,
  input  logic        alu_src,
  input  logic        fpu_a_sel,
  input  logic [2:0]  alu_control,
  input  logic [4:0]  fpu_sel_in,
  input  logic        dsrc,
  input  logic        mem_src,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  funct3,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [4:0]  fpu_op,
  input  logic [31:0] fpu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_read_data,
  output logic        out_zero,
  output logic        out_err
);

  localparam int AW        = $clog2(DEPTH_WORDS * 4);
  localparam int CW        = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FPU_WAIT,
    S_EXEC,
    S_RESP
  } state_t;

  state_t state;
  logic [CW-1:0] cnt;

  // Operation fields captured at accept; inputs are ignored afterwards.
  logic [31:0] a_q;
  logic [31:0] bf_q;
  logic [31:0] wd_q;
  logic [31:0] imm_q;
  logic        alu_src_q;
  logic [2:0]  alu_ctl_q;
  logic        dsrc_q;
  logic        mem_src_q;
  logic        mw_q;
  logic        mr_q;
  logic [2:0]  f3_q;
  logic [31:0] fres_q;

  // Data RAM: deliberately not reset.
  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- ALU
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  assign alu_b = alu_src_q ? imm_q : wd_q;

  always_comb begin
    alu_result = 32'd0;
    case (alu_ctl_q)
      3'b000:  alu_result = a_q + alu_b;
      3'b001:  alu_result = a_q - alu_b;
      3'b010:  alu_result = a_q & alu_b;
      3'b011:  alu_result = a_q | alu_b;
      3'b101:  alu_result = {31'd0, ($signed(a_q) < $signed(alu_b))};
      default: alu_result = 32'd0;
    endcase
  end

  // ------------------------------------------------------ address / error
  logic [31:0]   exec_result;
  logic [AW-1:0] addr;
  logic [1:0]    size;
  logic          access;
  logic          bad;
  logic          err;

  assign exec_result = dsrc_q ? fres_q : alu_result;
  assign addr        = exec_result[AW-1:0];
  assign size        = f3_q[1:0];
  assign access      = mr_q | mw_q;

  // Range check uses the full 32-bit result, not the truncated address.
  assign bad = (exec_result >= MEM_BYTES)
             | (size == 2'b11)
             | ((size == 2'b01) && addr[0])
             | ((size == 2'b10) && (addr[1:0] != 2'b00))
             | (mr_q & mw_q);
  assign err = access & bad;

  // ----------------------------------------------------------------- load
  logic [AW-3:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_ext;
  logic [31:0]   load_data;

  assign word_idx = addr[AW-1:2];
  assign rd_word  = mem[word_idx];
  // Bring the addressed lane down to bit 0; halfwords are known aligned here.
  assign rd_shift = rd_word >> {addr[1:0], 3'b000};

  always_comb begin
    ld_ext = rd_word;
    case (size)
      2'b00:   ld_ext = f3_q[2] ? {24'd0, rd_shift[7:0]}
                                : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = f3_q[2] ? {16'd0, rd_shift[15:0]}
                                : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = rd_word;
    endcase
  end

  assign load_data = (mr_q && !err) ? ld_ext : 32'd0;

  // ---------------------------------------------------------------- store
  logic [31:0] st_src;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        do_write;

  assign st_src = mem_src_q ? bf_q : wd_q;

  // Replicate the store data across lanes so each enabled lane picks its own slice.
  always_comb begin
    st_be   = 4'b0000;
    st_data = st_src;
    case (size)
      2'b00: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{st_src[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << addr[1:0];
        st_data = {2{st_src[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b1111;
        st_data = st_src;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = st_src;
      end
    endcase
  end

  // Reset forces the FSM out of EXEC, so an abandoned op never writes.
  assign do_write = (state == S_EXEC) && mw_q && !err;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem[word_idx][i*8 +: 8] <= st_data[i*8 +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_read_data <= 32'd0;
      out_zero      <= 1'b0;
      out_err       <= 1'b0;
      fpu_a         <= 32'd0;
      fpu_b         <= 32'd0;
      fpu_op        <= 5'd0;
      a_q           <= 32'd0;
      bf_q          <= 32'd0;
      wd_q          <= 32'd0;
      imm_q         <= 32'd0;
      alu_src_q     <= 1'b0;
      alu_ctl_q     <= 3'd0;
      dsrc_q        <= 1'b0;
      mem_src_q     <= 1'b0;
      mw_q          <= 1'b0;
      mr_q          <= 1'b0;
      f3_q          <= 3'd0;
      fres_q        <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            a_q       <= src_a;
            bf_q      <= src_bf;
            wd_q      <= write_data;
            imm_q     <= imm_ext;
            alu_src_q <= alu_src;
            alu_ctl_q <= alu_control;
            dsrc_q    <= dsrc;
            mem_src_q <= mem_src;
            mw_q      <= mem_write;
            mr_q      <= mem_read;
            f3_q      <= funct3;
            if (dsrc) begin
              fpu_a  <= fpu_a_sel ? src_a : src_af;
              fpu_b  <= src_bf;
              fpu_op <= fpu_sel_in;
              cnt    <= CW'(FPU_LAT - 1);
              state  <= S_FPU_WAIT;
            end else begin
              state <= S_EXEC;
            end
          end
        end

        S_FPU_WAIT: begin
          if (cnt == '0) begin
            fres_q <= fpu_result;
            state  <= S_EXEC;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_EXEC: begin
          out_result    <= exec_result;
          out_read_data <= load_data;
          out_zero      <= !dsrc_q && (alu_result == 32'd0);
          out_err       <= err;
          out_valid     <= 1'b1;
          state         <= S_RESP;
        end

        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// tb/tb_exmem_pipe_stage.sv - self-checking bench for exmem_pipe_stage
module tb_exmem_pipe_stage;

  localparam int DW = 64;
  localparam int FL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src_a = '0, src_af = '0, src_bf = '0, write_data = '0, imm_ext = '0;
  logic        alu_src = 1'b0, fpu_a_sel = 1'b0;
  logic [2:0]  alu_control = '0;
  logic [4:0]  fpu_sel_in = '0;
  logic        dsrc = 1'b0, mem_src = 1'b0, mem_write = 1'b0, mem_read = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] fpu_a, fpu_b;
  logic [4:0]  fpu_op;
  logic [31:0] fpu_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result, out_read_data;
  logic        out_zero, out_err;

  always #5 clk = ~clk;

  exmem_pipe_stage #(.DEPTH_WORDS(DW), .FPU_LAT(FL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_af(src_af), .src_bf(src_bf),
    .write_data(write_data), .imm_ext(imm_ext),
    .alu_src(alu_src), .fpu_a_sel(fpu_a_sel), .alu_control(alu_control),
    .fpu_sel_in(fpu_sel_in), .dsrc(dsrc), .mem_src(mem_src),
    .mem_write(mem_write), .mem_read(mem_read), .funct3(funct3),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_read_data(out_read_data),
    .out_zero(out_zero), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] a, af, bf, wd, imm;
    logic        alu_src, fsel_a;
    logic [2:0]  ctl;
    logic [4:0]  fop;
    logic        dsrc, msrc, mw, mr;
    logic [2:0]  f3;
    logic [31:0] fres, e_res, e_rd;
    logic        e_zero, e_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] res, rd;
    logic        zero, err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tab[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.a = '0; v.af = '0; v.bf = '0; v.wd = '0; v.imm = '0;
    v.alu_src = 1'b0; v.fsel_a = 1'b0; v.ctl = '0; v.fop = '0;
    v.dsrc = 1'b0; v.msrc = 1'b0; v.mw = 1'b0; v.mr = 1'b0; v.f3 = '0;
    v.fres = '0; v.e_res = '0; v.e_rd = '0; v.e_zero = 1'b0; v.e_err = 1'b0;
    v.hold = 0;
    return v;
  endfunction

  // Pure ALU op, no memory access.
  function automatic vec_t mka(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                               input logic use_imm, input logic [31:0] e_res);
    vec_t v = blank();
    v.ctl = ctl; v.a = a; v.alu_src = use_imm;
    if (use_imm) v.imm = b; else v.wd = b;
    v.e_res = e_res; v.e_zero = (e_res == 32'd0);
    return v;
  endfunction

  // Address computed by ALU add (a + imm), then optional load/store.
  function automatic vec_t mkm(input logic [31:0] a, input logic [31:0] imm, input logic mw, input logic mr,
                               input logic [2:0] f3, input logic [31:0] wd, input logic msrc,
                               input logic [31:0] bf, input logic [31:0] e_rd, input logic e_err);
    vec_t v = blank();
    v.ctl = 3'b000; v.alu_src = 1'b1; v.a = a; v.imm = imm;
    v.mw = mw; v.mr = mr; v.f3 = f3; v.wd = wd; v.msrc = msrc; v.bf = bf;
    v.e_res = a + imm; v.e_zero = ((a + imm) == 32'd0); v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  // FPU path: result (and address) comes from fres.
  function automatic vec_t mkf(input logic fsel_a, input logic [31:0] a, input logic [31:0] af,
                               input logic [31:0] bf, input logic [4:0] fop, input logic [31:0] fres,
                               input logic mw, input logic mr, input logic [2:0] f3, input logic msrc,
                               input logic [31:0] e_rd);
    vec_t v = blank();
    v.dsrc = 1'b1; v.fsel_a = fsel_a; v.a = a; v.af = af; v.bf = bf; v.fop = fop;
    v.fres = fres; v.mw = mw; v.mr = mr; v.f3 = f3; v.msrc = msrc; v.wd = 32'h5A5A_0F0F;
    v.e_res = fres; v.e_zero = 1'b0; v.e_rd = e_rd; v.e_err = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    src_a = v.a; src_af = v.af; src_bf = v.bf; write_data = v.wd; imm_ext = v.imm;
    alu_src = v.alu_src; fpu_a_sel = v.fsel_a; alu_control = v.ctl; fpu_sel_in = v.fop;
    dsrc = v.dsrc; mem_src = v.msrc; mem_write = v.mw; mem_read = v.mr; funct3 = v.f3;
    fpu_result = v.fres;
  endtask

  // Garbage on the inputs after accept: the stage must work from its latched copy.
  task automatic scramble();
    src_a = $urandom; src_af = $urandom; src_bf = $urandom; write_data = $urandom;
    imm_ext = $urandom; alu_src = 1'($urandom); fpu_a_sel = 1'($urandom);
    alu_control = 3'($urandom); fpu_sel_in = 5'($urandom); dsrc = 1'($urandom);
    mem_src = 1'($urandom); mem_write = 1'($urandom); mem_read = 1'($urandom);
    funct3 = 3'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    exp_t e;
    logic [31:0] ea;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
    drive(v);
    in_valid = 1'b1;
    e.res = v.e_res; e.rd = v.e_rd; e.zero = v.e_zero; e.err = v.e_err;
    e.lat = v.dsrc ? FL + 2 : 2;
    sb.push_back(e);
    ea = v.fsel_a ? v.a : v.af;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      if (v.dsrc && n <= FL) begin
        chk($sformatf("v%0d fpu_a c%0d", idx, n), fpu_a, ea);
        chk($sformatf("v%0d fpu_b c%0d", idx, n), fpu_b, v.bf);
        chk($sformatf("v%0d fpu_op c%0d", idx, n), 32'(fpu_op), 32'(v.fop));
      end
      n++;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d latency", idx), 32'(n), 32'(e.lat));
    chk($sformatf("v%0d out_result", idx), out_result, e.res);
    chk($sformatf("v%0d out_read_data", idx), out_read_data, e.rd);
    chk($sformatf("v%0d out_zero", idx), 32'(out_zero), 32'(e.zero));
    chk($sformatf("v%0d out_err", idx), 32'(out_err), 32'(e.err));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk($sformatf("v%0d hold%0d valid", idx, h), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d hold%0d result", idx, h), out_result, e.res);
      chk($sformatf("v%0d hold%0d in_ready", idx, h), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d valid drop", idx), 32'(out_valid), 32'd0);
    chk($sformatf("v%0d ready back", idx), 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;

    tab.push_back(mka(3'b000, 32'd5, 32'd7, 1'b1, 32'd12));
    tab[0].hold = 4;
    tab.push_back(mka(3'b001, 32'd5, 32'd5, 1'b0, 32'd0));
    tab.push_back(mka(3'b010, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 32'h0000_00F0));
    tab.push_back(mka(3'b011, 32'h0000_F000, 32'h0000_000F, 1'b1, 32'h0000_F00F));
    tab.push_back(mka(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1));
    tab.push_back(mka(3'b101, 32'd5, 32'hFFFF_FFFD, 1'b0, 32'd0));
    tab.push_back(mka(3'b100, 32'd3, 32'd4, 1'b0, 32'd0));
    tab.push_back(mka(3'b001, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF));
    tab.push_back(mka(3'b111, 32'd9, 32'd9, 1'b0, 32'd0));
    // sw / lb / lbu / lh / lw
    tab.push_back(mkm(32'h10, 32'h0, 1'b1, 1'b0, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 1'b0));
    tab.push_back(mkm(32'h10, 32'h3, 1'b0, 1'b1, 3'b000, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0));
    tab.push_back(mkm(32'h10, 32'h3, 1'b0, 1'b1, 3'b100, 32'h0, 1'b0, 32'h0, 32'h0000_00DE, 1'b0));
    tab.push_back(mkm(32'h10, 32'h2, 1'b0, 1'b1, 3'b001, 32'h0, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0));
    tab.push_back(mkm(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0));
    // error cases: misaligned sw, out of range lw, size 11, read+write, misaligned lh
    tab.push_back(mkm(32'h10, 32'h1, 1'b1, 1'b0, 3'b010, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b1));
    tab.push_back(mkm(32'h400, 32'h0, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1));
    tab.push_back(mkm(32'h10, 32'h0, 1'b0, 1'b1, 3'b011, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1));
    tab.push_back(mkm(32'h10, 32'h0, 1'b1, 1'b1, 3'b010, 32'h0BAD_0BAD, 1'b0, 32'h0, 32'h0, 1'b1));
    tab.push_back(mkm(32'h10, 32'h1, 1'b0, 1'b1, 3'b001, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1));
    tab.push_back(mkm(32'hFC, 32'h0, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
    tab[$].e_rd = 32'hx;
    tab.pop_back();
    tab.push_back(mkm(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0));
    // sb from src_bf into lane 1, sh / lhu / lh at 0x1A
    tab.push_back(mkm(32'h10, 32'h1, 1'b1, 1'b0, 3'b000, 32'h0, 1'b1, 32'h1234_5655, 32'h0, 1'b0));
    tab.push_back(mkm(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0));
    tab.push_back(mkm(32'h18, 32'h2, 1'b1, 1'b0, 3'b001, 32'h1234_CAFE, 1'b0, 32'h0, 32'h0, 1'b0));
    tab.push_back(mkm(32'h18, 32'h2, 1'b0, 1'b1, 3'b101, 32'h0, 1'b0, 32'h0, 32'h0000_CAFE, 1'b0));
    tab.push_back(mkm(32'h18, 32'h2, 1'b0, 1'b1, 3'b001, 32'h0, 1'b0, 32'h0, 32'hFFFF_CAFE, 1'b0));
    // no access with an out-of-range result: no error
    tab.push_back(mkm(32'h1000, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
    // FPU path
    tab.push_back(mkf(1'b0, 32'h1111_1111, 32'h3F80_0000, 32'h4000_0000, 5'h03, 32'h4040_0000,
                      1'b0, 1'b0, 3'b000, 1'b0, 32'h0));
    tab.push_back(mkf(1'b1, 32'h1111_1111, 32'h3F80_0000, 32'h2222_2222, 5'h1F, 32'h0,
                      1'b0, 1'b0, 3'b000, 1'b0, 32'h0));
    tab.push_back(mkf(1'b0, 32'h0, 32'h1, 32'hA5A5_A5A5, 5'h01, 32'h20,
                      1'b1, 1'b0, 3'b010, 1'b1, 32'h0));
    tab.push_back(mkm(32'h20, 32'h0, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b0));
    tab.push_back(mkf(1'b0, 32'h0, 32'h2, 32'h3, 5'h02, 32'h13,
                      1'b0, 1'b1, 3'b100, 1'b0, 32'h0000_00DE));

    // Reset state
    #2;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_read_data", out_read_data, 32'd0);
    chk("rst flags", {30'd0, out_zero, out_err}, 32'd0);
    chk("rst fpu_a", fpu_a, 32'd0);
    chk("rst fpu_b", fpu_b, 32'd0);
    chk("rst fpu_op", 32'(fpu_op), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel in_ready", 32'(in_ready), 32'd1);

    foreach (tab[i]) run_vec(tab[i], i);

    // Reset pulse in the middle of an FPU-path store to word 0x10
    v = mkf(1'b0, 32'h0, 32'h7, 32'h8, 5'h04, 32'h10, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0);
    drive(v);
    write_data = 32'h0BAD_F00D;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid fpu_a", fpu_a, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd0);
    chk("mid rst fpu_a", fpu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid rel in_ready", 32'(in_ready), 32'd1);
    repeat (FL + 3) begin
      @(negedge clk);
      chk("mid no valid", 32'(out_valid), 32'd0);
    end
    run_vec(mkm(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0), 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exmem_pipe_stage.md
EXMEM_PIPE_STAGE -- requirements
Module: exmem_pipe_stage

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, SHALL set data RAM size in 32-bit words (power of two, >=4); byte address width AW = log2(DEPTH_WORDS*4).
REQ-002 Parameter FPU_LAT, default 3, SHALL set FPU wait cycles (>=1).
REQ-003 Ports SHALL be:
 clk  in  1  single clock, rising edge
 rst_n  in  1  asynchronous, active-low reset
 in_valid / in_ready  in/out  1  operation handshake
 src_a, src_af, src_bf, write_data, imm_ext  in  32  integer A, float A, float B, integer B, immediate
 alu_src  in  1  ALU B select: 0 write_data, 1 imm_ext
 fpu_a_sel  in  1  FPU A select: 0 src_af, 1 src_a
 alu_control  in  3  ALU op
 fpu_sel_in  in  5  FPU op code
 dsrc  in  1  result select: 0 ALU, 1 FPU
 mem_src  in  1  store data: 0 write_data, 1 src_bf
 mem_write, mem_read  in  1  store / load request
 funct3  in  3  [1:0] size (00 B, 01 H, 10 W), [2] 1 = zero-extend
 fpu_a, fpu_b  out  32  operands to external FPU
 fpu_op  out  5  op to external FPU
 fpu_result  in  32  external FPU result
 out_valid / out_ready  out/in  1  result handshake
 out_result, out_read_data  out  32  ALU/FPU result, load data
 out_zero, out_err  out  1  ALU zero flag, access error

Function
REQ-004 All in_* fields SHALL be latched on the in_valid && in_ready cycle; later changes SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, FPU_WAIT, EXEC, RESP; in_ready = 1 only in IDLE.
REQ-006 IDLE: on accept -> FPU_WAIT with counter = FPU_LAT-1 if dsrc=1, else -> EXEC.
REQ-007 FPU_WAIT: fpu_a/fpu_b/fpu_op SHALL hold latched values; counter decrements; at 0, fpu_result SHALL be captured -> EXEC.
REQ-008 ALU: 000 add, 001 sub, 010 and, 011 or, 101 signed slt (0/1), others 0; 32-bit wrap-around, no overflow flag.
REQ-009 out_zero SHALL be 1 iff dsrc=0 and ALU result = 0; 0 on FPU path.
REQ-010 EXEC (one cycle): result = ALU or captured FPU; byte address = result[AW-1:0]; error if result >= DEPTH_WORDS*4, size=11, half with addr[0]=1, word with addr[1:0]!=0, or mem_read && mem_write.
REQ-011 EXEC store (no error): write only the selected little-endian byte lanes; other bytes unchanged.
REQ-012 EXEC load (no error): extract lanes little-endian, sign-extend if funct3[2]=0 else zero-extend, register into out_read_data.
REQ-013 On error: no RAM write, out_read_data = 0, out_err = 1; with neither mem_read nor mem_write, no access, out_err = 0, out_read_data = 0.
REQ-014 EXEC -> RESP; out_result/out_read_data/out_zero/out_err registered on that transition, held stable while out_valid=1.
REQ-015 RESP: out_valid = 1; on out_ready -> IDLE next cycle, out_valid deasserts; no new accept same cycle.
REQ-016 Latency in_accept->out_valid SHALL be 2 cycles (ALU), FPU_LAT+2 (FPU); throughput max one op per 3+ cycles.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, counter 0, in_ready 0, out_valid 0, all data/flag outputs and fpu_* outputs 0; in_ready = 1 from first cycle after release.
REQ-018 Reset mid-FPU_WAIT or EXEC SHALL abandon the op with no RAM write; RAM contents are not reset.

Verification
REQ-019 ALU add: src_a=5, imm_ext=7, alu_src=1, alu_control=000 -> out_valid 2 cycles after accept, out_result=12, out_zero=0.
REQ-020 Store/load: sw 0xDEADBEEF at 0x10, then lb addr 0x13 funct3=000 -> 0xFFFFFFDE; lbu 0x13 funct3=100 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD.
REQ-021 FPU path, FPU_LAT=3: fpu_result=0x40400000 -> fpu_a/fpu_b stable 3 cycles, out_valid 5 cycles after accept, out_result=0x40400000.
REQ-022 Misaligned sw at 0x11 and lw at 0x400 (DEPTH_WORDS=64) -> out_err=1, out_read_data=0, RAM word 0x10 unchanged.
REQ-023 Backpressure: out_ready=0 for 4 cycles -> out_valid and data held, in_ready=0; rst_n pulse during FPU_WAIT -> out_valid=0, in_ready=1 after release, no write.
